// File: rtl/video_timing_gen.sv
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Pixel-clock-domain raster timing generator. Waits until the
//            clock wizard's lock has been stable for LOCK_CYCLES synchronized
//            cycles, then produces sx/sy coordinates, hsync/vsync, data
//            enable and line/frame strobes, plus a completed-frame counter.
// Ports    : i_clk          pixel clock
//            reset          asynchronous active-high reset
//            i_locked       wizard lock (asynchronous to i_clk)
//            o_running      high while raster timing is running
//            o_sx, o_sy     horizontal / vertical position
//            o_hsync        horizontal sync (asserted level H_POL)
//            o_vsync        vertical sync (asserted level V_POL)
//            o_de           active-video enable
//            o_line         one-cycle strobe at sx == 0
//            o_frame        one-cycle strobe at sx == 0 && sy == 0
//            o_frame_count  completed-frame counter (wraps at 16 bits)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int   H_RES       = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_RES       = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   LOCK_CYCLES = 16,
  parameter int   CORDW       = 10
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_locked,
  output logic             o_running,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_line,
  output logic             o_frame,
  output logic [15:0]      o_frame_count
);

  localparam int c_h_total = H_RES + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_RES + V_FP + V_SYNC + V_BP;
  localparam int c_lock_w  = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

  localparam logic [CORDW-1:0] c_h_last   = CORDW'(c_h_total - 1);
  localparam logic [CORDW-1:0] c_v_last   = CORDW'(c_v_total - 1);
  localparam logic [CORDW-1:0] c_h_res    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] c_v_res    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] c_hs_start = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] c_hs_end   = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] c_vs_start = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] c_vs_end   = CORDW'(V_RES + V_FP + V_SYNC - 1);

  localparam logic [c_lock_w-1:0] c_lock_target = c_lock_w'(LOCK_CYCLES);

  localparam logic [0:0] c_st_wait_lock = 1'b0;
  localparam logic [0:0] c_st_run       = 1'b1;

  // Two-flop synchronizer for the asynchronous lock input.
  logic [1:0]          sync_q;
  logic                lock_s;

  logic [0:0]          state_q,     state_d;
  logic [c_lock_w-1:0] lock_cnt_q,  lock_cnt_d;
  logic [CORDW-1:0]    sx_q,        sx_d;
  logic [CORDW-1:0]    sy_q,        sy_d;
  logic                hsync_q,     hsync_d;
  logic                vsync_q,     vsync_d;
  logic                de_q,        de_d;
  logic                line_q,      line_d;
  logic                frame_q,     frame_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                run_d;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sx_d        = '0;
    sy_d        = '0;

    case (state_q)
      c_st_wait_lock: begin
        if (!lock_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == c_lock_target) begin
          // Enter RUN at the origin of a fresh frame.
          state_d    = c_st_run;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + c_lock_w'(1);
        end
      end

      c_st_run: begin
        if (!lock_s) begin
          state_d    = c_st_wait_lock;
          lock_cnt_d = '0;
        end else if (sx_q == c_h_last) begin
          if (sy_q == c_v_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            sy_d = sy_q + CORDW'(1);
          end
        end else begin
          sx_d = sx_q + CORDW'(1);
          sy_d = sy_q;
        end
      end

      default: state_d = c_st_wait_lock;
    endcase

    // Flags are derived from the next coordinates so that, once registered,
    // they line up with the sx/sy presented in the same cycle. Outside RUN
    // every flag falls back to its idle level.
    run_d   = (state_d == c_st_run);
    de_d    = run_d && (sx_d < c_h_res) && (sy_d < c_v_res);
    hsync_d = (run_d && (sx_d >= c_hs_start) && (sx_d <= c_hs_end)) ? H_POL : ~H_POL;
    vsync_d = (run_d && (sy_d >= c_vs_start) && (sy_d <= c_vs_end)) ? V_POL : ~V_POL;
    line_d  = run_d && (sx_d == '0);
    frame_d = line_d && (sy_d == '0);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b00;
      state_q     <= c_st_wait_lock;
      lock_cnt_q  <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      sync_q      <= {sync_q[0], i_locked};
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_running     = (state_q == c_st_run);
  assign o_sx          = sx_q;
  assign o_sy          = sy_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_line        = line_q;
  assign o_frame       = frame_q;
  assign o_frame_count = frame_cnt_q;

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-timing generator in the pixel-clock domain, directly downstream of the clock wizard.
- Consumes the wizard's 25 MHz pixel clock and its lock indicator.
- Holds the display pipeline idle until lock has been stable for a programmable time.
- Then produces 640x480@60 raster coordinates, sync pulses, data-enable and line/frame strobes for the pixel-generation and TMDS stages.

Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- LOCK_CYCLES, 16, consecutive synchronized-lock cycles required before RUN (>=1)
- CORDW, 10, coordinate width

Ports:
- i_clk  input  1  pixel clock (wizard 25 MHz output)
- reset  input  1  asynchronous, active-high reset
- i_locked  input  1  wizard lock, asynchronous to i_clk
- o_running  output  1  high while in RUN
- o_sx  output  CORDW  horizontal counter
- o_sy  output  CORDW  vertical counter
- o_hsync  output  1  horizontal sync
- o_vsync  output  1  vertical sync
- o_de  output  1  active-video enable
- o_line  output  1  one-cycle strobe at start of each line
- o_frame  output  1  one-cycle strobe at start of each frame
- o_frame_count  output  16  completed-frame counter

Behaviour:
- Derived totals: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525).
- Reset (asynchronous, active-high) clears everything immediately:
  - State goes to WAIT_LOCK; synchronizer flops and lock counter cleared.
  - o_running=0, o_sx=0, o_sy=0, o_de=0, o_line=0, o_frame=0, o_frame_count=0.
  - o_hsync=~H_POL, o_vsync=~V_POL.
- i_locked passes through a 2-flop synchronizer (lock_s); all logic uses lock_s only.
- WAIT_LOCK:
  - Lock counter increments while lock_s=1; clears whenever lock_s=0.
  - When the counter reaches LOCK_CYCLES, go to RUN.
  - If i_locked rises before clock edge k, the first RUN cycle is edge k+LOCK_CYCLES+2.
  - Throughout WAIT_LOCK, all outputs hold their reset values; o_frame_count is retained.
- RUN:
  - Each cycle, o_sx increments; at H_TOTAL-1 it wraps to 0 and o_sy increments.
  - o_sy wraps from V_TOTAL-1 to 0 on that same sx wrap.
  - First RUN cycle: o_running=1, o_sx=0, o_sy=0.
- Flag alignment: all flags are registered and correspond to the o_sx/o_sy values presented in the same cycle.
  - o_de = (sx<H_RES) && (sy<V_RES).
  - o_hsync = H_POL when H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1, else ~H_POL.
  - o_vsync = V_POL when V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1 (whole lines), else ~V_POL.
  - o_line = (sx==0); o_frame = (sx==0 && sy==0), including the first RUN cycle.
- o_frame_count:
  - Increments by 1, wrapping 0xFFFF->0, on every sy wrap V_TOTAL-1 -> 0.
  - The new value is visible in the cycle where o_frame=1.
  - The first frame after entering RUN does not increment it.
- Lock loss: lock_s=0 while in RUN forces WAIT_LOCK on the next edge, with the same output values as reset except o_frame_count.
  - Relock requires a fresh LOCK_CYCLES count; timing restarts at sx=0, sy=0.
- Reset asserted mid-line or mid-frame: outputs go to reset values asynchronously, with no partial pulse extension.
- Counter widths: CORDW must hold H_TOTAL-1 and V_TOTAL-1; no other arithmetic overflow is possible.

Test Plan:
- Reset assert/release with i_locked=0 for 100 cycles -> o_running=0, o_hsync=1, o_vsync=1, o_de=0, counters 0 throughout.
- i_locked rises before edge k -> o_running first high at edge k+18, o_sx=0, o_sy=0, o_frame=1, o_line=1, o_de=1, o_frame_count=0.
- One line in RUN:
  - o_de high exactly for sx 0..639.
  - o_hsync low exactly for sx 656..751.
  - o_line high only at sx=0; o_sx wraps 799->0.
- One frame in RUN:
  - o_vsync low exactly for sy 490..491.
  - o_de low for all sy>=480.
  - o_sy wraps 524->0 with o_frame=1 and o_frame_count=1.
- i_locked low for 1 cycle mid-frame -> WAIT_LOCK within 3 edges, outputs idle, o_frame_count held; RUN re-entered LOCK_CYCLES+2 edges after i_locked returns high, at sx=0, sy=0.
- Asynchronous reset pulse between clock edges mid-hsync -> o_hsync=1, o_running=0, o_frame_count=0 before the next edge; relock runs a normal sequence.
